// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Control block for the fetch stage of a 5-stage MIPS pipeline. Decides every
// cycle whether the PC and IF/ID advance, whether the PC takes the branch
// target, and which pipeline registers are flushed. Handles, in priority
// order: MEM-stage branch redirects, load-use stalls and normal advance. A run
// of NOP_HALT_COUNT consecutive all-zero fetched words marks end of program.
// The block then drains the back of the pipe for DRAIN_CYCLES cycles and
// parks in a halted state that only rst leaves.
//
// Optional build macro: FETCH_SEQ_PERF_EN adds three 32-bit performance
// counters (cycles, stall cycles, redirect cycles).
//
// Ports:
//   clk                 pipeline clock, rising edge
//   rst                 synchronous active-high reset
//   in_instruction      word currently presented by the fetch stage
//   in_if_id_rs/rt      source register fields of the instruction in IF/ID
//   in_id_ex_mem_read   instruction in ID/EX is a load
//   in_id_ex_rt         destination of the instruction in ID/EX
//   in_branch_taken     branch resolved taken in MEM this cycle
//   out_pc_write        PC update enable
//   out_pc_src          1 = branch target, 0 = PC+4
//   out_if_id_write     IF/ID update enable
//   out_if_id_flush     zero IF/ID on next edge
//   out_id_ex_flush     zero ID/EX on next edge (bubble)
//   out_ex_mem_flush    zero EX/MEM on next edge
//   out_halted          program complete, pipeline stopped
//   out_cycle_count     (perf build) non-halted cycles
//   out_stall_count     (perf build) load-use stall cycles
//   out_redirect_count  (perf build) redirect cycles
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int NOP_HALT_COUNT = 4,   // legal 1..15
    parameter int DRAIN_CYCLES   = 3    // legal 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_instruction,
    input  logic [4:0]  in_if_id_rs,
    input  logic [4:0]  in_if_id_rt,
    input  logic        in_id_ex_mem_read,
    input  logic [4:0]  in_id_ex_rt,
    input  logic        in_branch_taken,
    output logic        out_pc_write,
    output logic        out_pc_src,
    output logic        out_if_id_write,
    output logic        out_if_id_flush,
    output logic        out_id_ex_flush,
    output logic        out_ex_mem_flush,
    output logic        out_halted
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0] out_cycle_count,
    output logic [31:0] out_stall_count,
    output logic [31:0] out_redirect_count
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] NOP_LAST   = 4'(NOP_HALT_COUNT - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] nop_cnt_q, nop_cnt_d;
    logic [2:0] drain_cnt_q, drain_cnt_d;

    logic load_use;
    logic instr_zero;
    logic stall_evt;
    logic redirect_evt;

    // $0 is hard-wired zero, so a load "writing" it never creates a hazard.
    assign load_use = in_id_ex_mem_read && (in_id_ex_rt != 5'd0) &&
                      ((in_id_ex_rt == in_if_id_rs) || (in_id_ex_rt == in_if_id_rt));
    assign instr_zero = (in_instruction == 32'd0);

    assign redirect_evt = in_branch_taken && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign stall_evt    = (state_q == ST_RUN) && !in_branch_taken && load_use;

    // Next-state and outputs. Outputs are combinational so a redirect or
    // stall is applied at the very next edge; rst overrides everything with
    // a safe "flush all, advance nothing" pattern.
    always_comb begin
        state_d          = state_q;
        nop_cnt_d        = nop_cnt_q;
        drain_cnt_d      = drain_cnt_q;
        out_pc_write     = 1'b0;
        out_pc_src       = 1'b0;
        out_if_id_write  = 1'b0;
        out_if_id_flush  = 1'b0;
        out_id_ex_flush  = 1'b0;
        out_ex_mem_flush = 1'b0;
        out_halted       = 1'b0;

        if (rst) begin
            out_if_id_flush  = 1'b1;
            out_id_ex_flush  = 1'b1;
            out_ex_mem_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (in_branch_taken) begin
                        out_pc_src       = 1'b1;
                        out_pc_write     = 1'b1;
                        out_if_id_write  = 1'b1;
                        out_if_id_flush  = 1'b1;
                        out_id_ex_flush  = 1'b1;
                        out_ex_mem_flush = 1'b1;
                        nop_cnt_d        = 4'd0;
                    end else if (load_use) begin
                        // Freeze PC and IF/ID, inject a bubble; the word in
                        // fetch is re-presented so the nop run is unaffected.
                        out_id_ex_flush = 1'b1;
                    end else begin
                        out_pc_write    = 1'b1;
                        out_if_id_write = 1'b1;
                        if (instr_zero) begin
                            if (nop_cnt_q == NOP_LAST) begin
                                state_d     = ST_DRAIN;
                                nop_cnt_d   = 4'd0;
                                drain_cnt_d = 3'd0;
                            end else begin
                                nop_cnt_d = nop_cnt_q + 4'd1;
                            end
                        end else begin
                            nop_cnt_d = 4'd0;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (in_branch_taken) begin
                        // A late branch means the zero run was on a wrong
                        // path: abort the drain and redirect as in RUN.
                        out_pc_src       = 1'b1;
                        out_pc_write     = 1'b1;
                        out_if_id_write  = 1'b1;
                        out_if_id_flush  = 1'b1;
                        out_id_ex_flush  = 1'b1;
                        out_ex_mem_flush = 1'b1;
                        nop_cnt_d        = 4'd0;
                        state_d          = ST_RUN;
                    end else begin
                        // PC frozen, IF/ID loaded with zeros each cycle so only
                        // bubbles follow the last real instruction down the pipe.
                        out_if_id_write = 1'b1;
                        out_if_id_flush = 1'b1;
                        if (drain_cnt_q == DRAIN_LAST) begin
                            state_d = ST_HALT;
                        end else begin
                            drain_cnt_d = drain_cnt_q + 3'd1;
                        end
                    end
                end

                ST_HALT: begin
                    out_halted = 1'b1;
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            nop_cnt_q   <= 4'd0;
            drain_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            nop_cnt_q   <= nop_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] stall_cnt_q;
    logic [31:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q    <= 32'd0;
            stall_cnt_q    <= 32'd0;
            redirect_cnt_q <= 32'd0;
        end else begin
            if (state_q != ST_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if (stall_evt) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_evt) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign out_cycle_count    = cycle_cnt_q;
    assign out_stall_count    = stall_cnt_q;
    assign out_redirect_count = redirect_cnt_q;
`else
    // Event decodes only feed the optional counters.
    logic unused_evt;
    assign unused_evt = stall_evt ^ redirect_evt;
`endif

endmodule
